// File: rtl/bf_pkg.sv
// Shared brainfuck definitions: opcodes, upload FSM encoding, error codes and decoder payload.
package bf_pkg;

  localparam int unsigned OPC_W    = 4;
  localparam int unsigned ERR_W    = 2;
  localparam int unsigned CHAR_W   = 8;

  localparam logic [OPC_W-1:0] OP_HALT    = 4'd0;
  localparam logic [OPC_W-1:0] OP_INC_PTR = 4'd1;
  localparam logic [OPC_W-1:0] OP_DEC_PTR = 4'd2;
  localparam logic [OPC_W-1:0] OP_INC     = 4'd3;
  localparam logic [OPC_W-1:0] OP_DEC     = 4'd4;
  localparam logic [OPC_W-1:0] OP_OUT     = 4'd5;
  localparam logic [OPC_W-1:0] OP_IN      = 4'd6;
  localparam logic [OPC_W-1:0] OP_JZ      = 4'd7;
  localparam logic [OPC_W-1:0] OP_JNZ     = 4'd8;

  localparam logic [ERR_W-1:0] ERR_NONE     = 2'd0;
  localparam logic [ERR_W-1:0] ERR_UNM_CLOSE = 2'd1;
  localparam logic [ERR_W-1:0] ERR_UNM_OPEN  = 2'd2;
  localparam logic [ERR_W-1:0] ERR_TOO_LONG  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TERM  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } upload_state_e;

  typedef struct packed {
    logic             is_op;
    logic [OPC_W-1:0] opcode;
  } bf_dec_t;

endpackage

// File: rtl/bf_char_decoder.sv
// ASCII to brainfuck opcode decoder; non-op characters report is_op=0 and OP_HALT.
module bf_char_decoder
  import bf_pkg::*;
(
  input  logic [CHAR_W-1:0] char_i,
  output bf_dec_t           dec_o
);

  always_comb begin
    dec_o = '{is_op: 1'b1, opcode: OP_HALT};
    case (char_i)
      8'h3E:   dec_o.opcode = OP_INC_PTR; // '>'
      8'h3C:   dec_o.opcode = OP_DEC_PTR; // '<'
      8'h2B:   dec_o.opcode = OP_INC;     // '+'
      8'h2D:   dec_o.opcode = OP_DEC;     // '-'
      8'h2E:   dec_o.opcode = OP_OUT;     // '.'
      8'h2C:   dec_o.opcode = OP_IN;      // ','
      8'h5B:   dec_o.opcode = OP_JZ;      // '['
      8'h5D:   dec_o.opcode = OP_JNZ;     // ']'
      default: dec_o.is_op  = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_upload_ctrl.sv
// Program upload sequencer: filters the host byte stream to ops, writes opcodes to program
// memory, checks bracket balance and terminates the image with HALT.
module bf_upload_ctrl
  import bf_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DEPTH_W   = 8,
  parameter logic [CHAR_W-1:0] TERM_CHAR = 8'h21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAR_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OPC_W-1:0]  mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ERR_W-1:0]  err_code,
  output logic [ADDR_W-1:0] prog_len
);

  localparam logic [ADDR_W-1:0]  ADDR_MAX  = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  upload_state_e      state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [ADDR_W-1:0]  prog_len_q, prog_len_d;
  logic [ERR_W-1:0]   err_code_q, err_code_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [OPC_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  bf_dec_t dec;
  logic    accept;

  bf_char_decoder u_dec (
    .char_i (rx_data),
    .dec_o  (dec)
  );

  assign accept = rx_valid && (state_q == ST_LOAD);

  // Next-state, counter and write-register logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    depth_d     = depth_q;
    prog_len_d  = prog_len_q;
    err_code_d  = err_code_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_d    = ST_LOAD;
            addr_d     = '0;
            depth_d    = '0;
            prog_len_d = '0;
            err_code_d = ERR_NONE;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (dec.is_op) begin
              // Last word stays free for HALT; bracket checks fire before depth can wrap
              if (addr_q == ADDR_MAX) begin
                state_d    = ST_ERROR;
                err_code_d = ERR_TOO_LONG;
              end else if (dec.opcode == OP_JZ && depth_q == DEPTH_MAX) begin
                state_d    = ST_ERROR;
                err_code_d = ERR_UNM_OPEN;
              end else if (dec.opcode == OP_JNZ && depth_q == '0) begin
                state_d    = ST_ERROR;
                err_code_d = ERR_UNM_CLOSE;
              end else begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = dec.opcode;
                addr_d      = addr_q + ADDR_W'(1);
                prog_len_d  = prog_len_q + ADDR_W'(1);
                if (dec.opcode == OP_JZ) begin
                  depth_d = depth_q + DEPTH_W'(1);
                end else if (dec.opcode == OP_JNZ) begin
                  depth_d = depth_q - DEPTH_W'(1);
                end
              end
            end else if (rx_data == TERM_CHAR) begin
              state_d = ST_TERM;
            end
          end
        end
        ST_TERM: begin
          if (depth_q != '0) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_UNM_OPEN;
          end else begin
            state_d     = ST_DONE;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = OP_HALT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d  = (state_d == ST_LOAD) || (state_d == ST_TERM);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      depth_q     <= '0;
      prog_len_q  <= '0;
      err_code_q  <= ERR_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      depth_q     <= depth_d;
      prog_len_q  <= prog_len_d;
      err_code_q  <= err_code_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rx_ready  = (state_q == ST_LOAD);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign prog_len  = prog_len_q;

endmodule

// File: tb/tb_bf_upload_ctrl.sv
// Directed bench for bf_upload_ctrl: vector table of whole programs plus hand-written
// sequences for max-length, abort and reset corner cases.
module tb_bf_upload_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready, mem_we, busy, done, error;
  logic [9:0] mem_addr, prog_len;
  logic [3:0] mem_wdata;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;

  int wr_addr[$];
  int wr_data[$];

  bf_upload_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .prog_len  (prog_len)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(int'(mem_wdata));
    end
  end

  typedef struct {
    string       prog;
    bit          gaps;
    int          n_wr;
    logic [31:0] ops;
    bit          exp_done;
    bit          exp_err;
    int          exp_code;
    int          exp_len;
  } vec_t;

  function automatic vec_t mk(input string p, input bit g, input int n, input logic [31:0] o,
                              input bit d, input bit e, input int c, input int l);
    vec_t v;
    v.prog = p; v.gaps = g; v.n_wr = n; v.ops = o;
    v.exp_done = d; v.exp_err = e; v.exp_code = c; v.exp_len = l;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: rx_ready=0 after %0d cycles, required 1", n);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  vec_t vecs[6];
  int   errs;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    rst = 1'b0;
    idle(1);

    chk("reset_outputs_or", int'({rx_ready, mem_we, busy, done, error}), 0);
    chk("reset_mem_addr", int'(mem_addr), 0);
    chk("reset_mem_wdata", int'(mem_wdata), 0);
    chk("reset_err_code", int'(err_code), 0);
    chk("reset_prog_len", int'(prog_len), 0);

    vecs[0] = mk("+[->+<]!",  1'b0, 8, 32'h0823_1473, 1'b1, 1'b0, 0, 7);
    vecs[1] = mk("a+ b\n-!",  1'b1, 3, 32'h0000_0043, 1'b1, 1'b0, 0, 2);
    vecs[2] = mk("+]",        1'b0, 1, 32'h0000_0003, 1'b0, 1'b1, 1, 1);
    vecs[3] = mk("[[+]!",     1'b0, 4, 32'h0000_8377, 1'b0, 1'b1, 2, 4);
    vecs[4] = mk("><.,!",     1'b1, 5, 32'h0006_5021 | 32'h0, 1'b1, 1'b0, 0, 4);
    vecs[5] = mk("]",         1'b0, 0, 32'h0000_0000, 1'b0, 1'b1, 1, 0);
    // "><.,!" -> 1,2,5,6,HALT
    vecs[4].ops = 32'h0006_5221 & 32'h000F_FFFF;
    vecs[4].ops = {12'h000, 4'h0, 4'h6, 4'h5, 4'h2, 4'h1};

    for (int v = 0; v < 6; v++) begin
      pulse_start();
      chk($sformatf("v%0d_busy_after_start", v), int'(busy), 1);
      for (int i = 0; i < vecs[v].prog.len(); i++) begin
        send_byte(vecs[v].prog[i]);
        if (vecs[v].gaps) idle(2);
      end
      idle(4);
      chk($sformatf("v%0d_n_writes", v), wr_addr.size(), vecs[v].n_wr);
      for (int i = 0; i < vecs[v].n_wr && i < wr_addr.size(); i++) begin
        chk($sformatf("v%0d_addr%0d", v, i), wr_addr[i], i);
        chk($sformatf("v%0d_data%0d", v, i), wr_data[i], int'(vecs[v].ops[4*i +: 4]));
      end
      chk($sformatf("v%0d_done", v), int'(done), int'(vecs[v].exp_done));
      chk($sformatf("v%0d_error", v), int'(error), int'(vecs[v].exp_err));
      chk($sformatf("v%0d_err_code", v), int'(err_code), vecs[v].exp_code);
      chk($sformatf("v%0d_prog_len", v), int'(prog_len), vecs[v].exp_len);
      chk($sformatf("v%0d_rx_ready", v), int'(rx_ready), 0);
      chk($sformatf("v%0d_busy", v), int'(busy), 0);
    end

    // Maximum length program, then one more op
    pulse_start();
    for (int i = 0; i < 1023; i++) send_byte(8'h2B);
    send_byte(8'h2B);
    idle(4);
    chk("long_n_writes", wr_addr.size(), 1023);
    errs = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] != i || wr_data[i] != 3) errs++;
    chk("long_bad_words", errs, 0);
    chk("long_error", int'(error), 1);
    chk("long_err_code", int'(err_code), 3);
    chk("long_prog_len", int'(prog_len), 1023);

    // Maximum length program terminated: HALT lands in the last word
    pulse_start();
    for (int i = 0; i < 1023; i++) send_byte(8'h2B);
    send_byte(8'h21);
    idle(4);
    chk("full_n_writes", wr_addr.size(), 1024);
    if (wr_addr.size() == 1024) begin
      chk("full_halt_addr", wr_addr[1023], 1023);
      chk("full_halt_data", wr_data[1023], 0);
    end
    chk("full_done", int'(done), 1);
    chk("full_prog_len", int'(prog_len), 1023);

    // abort together with start and a valid byte mid-LOAD
    pulse_start();
    send_byte(8'h2B);
    send_byte(8'h2D);
    rx_data = 8'h2B; rx_valid = 1'b1; abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0; rx_valid = 1'b0;
    chk("abort_mem_we", int'(mem_we), 0);
    idle(3);
    chk("abort_n_writes", wr_addr.size(), 2);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rx_ready", int'(rx_ready), 0);
    chk("abort_done_err", int'({done, error}), 0);

    // Reset mid-stream, then reload from address 0
    pulse_start();
    send_byte(8'h2B);
    send_byte(8'h2B);
    rx_data = 8'h2B; rx_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rx_valid = 1'b0;
    chk("rst_flags", int'({rx_ready, mem_we, busy, done, error}), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_err_prog", int'({err_code, prog_len}), 0);
    idle(2);
    pulse_start();
    send_byte(8'h2D);
    send_byte(8'h21);
    idle(4);
    chk("reload_n_writes", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk("reload_addr0", wr_addr[0], 0);
      chk("reload_data0", wr_data[0], 4);
      chk("reload_addr1", wr_addr[1], 1);
      chk("reload_data1", wr_data[1], 0);
    end
    chk("reload_done", int'(done), 1);
    chk("reload_prog_len", int'(prog_len), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
